// File: rtl/snd_clkgen.sv
// snd_clkgen - audio clock generator for the sound path.
//
// Derives the codec master clock, bit clock and word clock from the fabric
// system clock with a fractional phase accumulator. Each accumulator carry
// advances a small frame counter (fc) whose bits are the audio clocks, so all
// three clocks stay phase-locked to each other. Rate changes and stops are
// only taken at a frame boundary, which keeps every clock glitch-free.
//
// Parameters:
//   ACC_W   - phase accumulator width
//   MCLK_FS - MCLK/fs ratio (power of 2, >= 4)
//   BCLK_FS - BCLK/fs ratio (power of 2, >= 2, MCLK_FS/BCLK_FS >= 2)
//   INC0..3 - accumulator increments for the four selectable rates;
//             INCn = round(2*MCLK_FS*fs/f_CLK * 2^ACC_W), each < 2^(ACC_W-1)
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous active-high reset
//   EN         in   run request, sampled at frame boundaries while running
//   FS_SEL     in   requested rate index, sampled at frame boundaries
//   SND_MCLK   out  master clock (fc[0])
//   SND_BCLK   out  bit clock (fc[BT])
//   SND_LRCK   out  word clock, 0 = left, 1 = right (fc msb)
//   BCLK_FALL  out  one-CLK strobe in the cycle SND_BCLK falls
//   FRAME      out  one-CLK strobe in the cycle SND_LRCK falls
//   RUNNING    out  high while generating clocks
//   ACTIVE_SEL out  rate index currently being generated

module snd_clkgen #(
  parameter int               ACC_W   = 32,
  parameter int               MCLK_FS = 256,
  parameter int               BCLK_FS = 64,
  parameter logic [ACC_W-1:0] INC0    = ACC_W'(1055531163),
  parameter logic [ACC_W-1:0] INC1    = ACC_W'(969769256),
  parameter logic [ACC_W-1:0] INC2    = ACC_W'(703687442),
  parameter logic [ACC_W-1:0] INC3    = ACC_W'(2111062325)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [1:0] FS_SEL,
  output logic       SND_MCLK,
  output logic       SND_BCLK,
  output logic       SND_LRCK,
  output logic       BCLK_FALL,
  output logic       FRAME,
  output logic       RUNNING,
  output logic [1:0] ACTIVE_SEL
);

  // fc counts MCLK half-periods across one frame; BT picks the BCLK tap.
  localparam int FC_W = $clog2(2 * MCLK_FS);
  localparam int BT   = $clog2(MCLK_FS / BCLK_FS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_inc;
  logic [FC_W-1:0]    r_fc;
  logic [1:0]         r_activeSel;
  logic               r_bclkFall;
  logic               r_frame;

  logic [ACC_W-1:0]   w_selInc;
  logic [ACC_W-1:0]   w_stepInc;
  logic [ACC_W:0]     w_sum;
  logic               w_carry;
  logic               w_rateChange;
  logic [ACC_W-1:0]   w_nextAcc;
  logic [ACC_W-1:0]   w_nextInc;
  logic [FC_W-1:0]    w_nextFc;
  logic [1:0]         w_nextSel;
  logic               w_nextBclkFall;
  logic               w_nextFrame;

  // Increment for the rate currently requested on FS_SEL.
  always_comb begin
    w_selInc = INC0;
    case (FS_SEL)
      2'd0:    w_selInc = INC0;
      2'd1:    w_selInc = INC1;
      2'd2:    w_selInc = INC2;
      default: w_selInc = INC3;
    endcase
  end

  // r_frame is high in the boundary cycle, so its closing edge is where a
  // pending rate change lands. The new increment is already used for that
  // edge's step, so the new frame runs entirely at the new rate. No carry can
  // occur on that step: acc is below the old increment right after a carry,
  // and both increments are below half the accumulator range.
  assign w_rateChange = r_frame && (FS_SEL != r_activeSel);
  assign w_stepInc    = w_rateChange ? w_selInc : r_inc;
  assign w_sum        = {1'b0, r_acc} + {1'b0, w_stepInc};
  assign w_carry      = w_sum[ACC_W];

  // Next-state and datapath update. A stop request at the boundary wins over
  // a rate change, so ACTIVE_SEL keeps the rate that was last generated.
  always_comb begin
    w_nextState    = r_state;
    w_nextAcc      = r_acc;
    w_nextInc      = r_inc;
    w_nextFc       = r_fc;
    w_nextSel      = r_activeSel;
    w_nextBclkFall = 1'b0;
    w_nextFrame    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_nextAcc = '0;
        w_nextFc  = '0;
        if (EN) begin
          w_nextState = ST_RUN;
          w_nextSel   = FS_SEL;
          w_nextInc   = w_selInc;
        end
      end
      ST_RUN: begin
        if (r_frame && !EN) begin
          w_nextState = ST_IDLE;
          w_nextAcc   = '0;
          w_nextFc    = '0;
        end else begin
          w_nextAcc = w_sum[ACC_W-1:0];
          if (w_carry) begin
            w_nextFc = r_fc + FC_W'(1);
          end
          w_nextBclkFall = w_carry && (&r_fc[BT:0]);
          w_nextFrame    = w_carry && (&r_fc);
          if (w_rateChange) begin
            w_nextSel = FS_SEL;
            w_nextInc = w_selInc;
          end
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Accumulator, frame counter, rate selection and strobes. Reset clears fc
  // immediately, so the audio clocks drop even in the middle of a frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_acc       <= '0;
      r_inc       <= INC0;
      r_fc        <= '0;
      r_activeSel <= 2'd0;
      r_bclkFall  <= 1'b0;
      r_frame     <= 1'b0;
    end else begin
      r_acc       <= w_nextAcc;
      r_inc       <= w_nextInc;
      r_fc        <= w_nextFc;
      r_activeSel <= w_nextSel;
      r_bclkFall  <= w_nextBclkFall;
      r_frame     <= w_nextFrame;
    end
  end

  // Clock outputs are plain taps of the registered frame counter.
  assign SND_MCLK   = r_fc[0];
  assign SND_BCLK   = r_fc[BT];
  assign SND_LRCK   = r_fc[FC_W-1];
  assign BCLK_FALL  = r_bclkFall;
  assign FRAME      = r_frame;
  assign RUNNING    = (r_state == ST_RUN);
  assign ACTIVE_SEL = r_activeSel;

endmodule
